// File: rtl/vx_packet_rr_scheduler_pkg.sv
// Shared helpers for the packet round-robin scheduler.
// Contents:
//   log2up - width of an index for n entries, never less than 1 bit
package vx_packet_rr_scheduler_pkg;

   function automatic int log2up(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/vx_packet_rr_scheduler_chk.sv
// Simulation-only properties for the packet scheduler grant vector.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   ready_in    per-requester accept from the scheduler
//   locked      scheduler is inside a packet
//   owner       requester that holds the packet lock
module vx_packet_rr_scheduler_chk #(
   parameter int NUM_REQS     = 4,
   parameter int LOG_NUM_REQS = 2
) (
   input logic                    clk,
   input logic                    reset,
   input logic [NUM_REQS-1:0]     ready_in,
   input logic                    locked,
   input logic [LOG_NUM_REQS-1:0] owner
);
   logic [NUM_REQS-1:0] others_s;

   // Mask of every requester except the current owner
   always_comb begin
      others_s = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         others_s[i] = (owner != LOG_NUM_REQS'(i));
      end
   end

   a_ready_onehot0: assert property (@(posedge clk) disable iff (reset)
      $onehot0(ready_in))
      else $error("ready_in has more than one bit set: %b", ready_in);

   a_locked_owner_only: assert property (@(posedge clk) disable iff (reset)
      locked |-> ((ready_in & others_s) == '0))
      else $error("ready_in %b grants a non-owner while locked on %0d", ready_in, owner);

endmodule

// File: rtl/vx_packet_rr_scheduler_rr_pick.sv
// Combinational rotating-priority pick.
// Doubles the request vector, masks off positions below the start index and
// takes the lowest remaining bit, which gives an upward search that wraps.
// Ports:
//   requests    in  NUM_REQS      request vector
//   start_idx   in  LOG_NUM_REQS  highest-priority index (must be < NUM_REQS)
//   pick_idx    out LOG_NUM_REQS  index of the chosen request
//   pick_onehot out NUM_REQS      one-hot of the chosen request, zero if none
//   pick_valid  out 1             at least one request present
module vx_rr_pick
   import vx_packet_rr_scheduler_pkg::*;
#(
   parameter int NUM_REQS     = 4,
   parameter int LOG_NUM_REQS = log2up(NUM_REQS)
) (
   input  logic [NUM_REQS-1:0]     requests,
   input  logic [LOG_NUM_REQS-1:0] start_idx,
   output logic [LOG_NUM_REQS-1:0] pick_idx,
   output logic [NUM_REQS-1:0]     pick_onehot,
   output logic                    pick_valid
);
   localparam int DBL_W = 2 * NUM_REQS;

   logic [DBL_W-1:0] dbl_s;
   logic [DBL_W-1:0] mask_s;
   logic [DBL_W-1:0] masked_s;

   // Mask-and-priority-encode over the doubled request vector
   always_comb begin
      dbl_s    = {requests, requests};
      mask_s   = '0;
      for (int i = 0; i < DBL_W; i++) begin
         mask_s[i] = (i >= int'(start_idx)) ? 1'b1 : 1'b0;
      end
      masked_s = dbl_s & mask_s;
      pick_idx = '0;
      // scan downward so the lowest set position wins
      for (int i = DBL_W - 1; i >= 0; i--) begin
         if (masked_s[i]) begin
            pick_idx = LOG_NUM_REQS'(i % NUM_REQS);
         end else begin
            pick_idx = pick_idx;
         end
      end
      pick_valid  = |requests;
      pick_onehot = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         pick_onehot[i] = pick_valid && (pick_idx == LOG_NUM_REQS'(i));
      end
   end

endmodule

// File: rtl/vx_packet_rr_scheduler.sv
// Packet round-robin scheduler: shares one registered valid/ready channel
// among NUM_REQS requesters; a grant is held from first beat to last=1.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   valid_in    per-requester beat valid
//   data_in     requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   last_in     beat closes its packet
//   ready_in    per-requester accept, one-hot or zero
//   valid_out   registered output valid
//   data_out    registered payload
//   last_out    registered last
//   sel_out     source requester of the output beat
//   ready_out   consumer accept
module vx_packet_rr_scheduler
   import vx_packet_rr_scheduler_pkg::*;
#(
   parameter int NUM_REQS     = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int LOG_NUM_REQS = log2up(NUM_REQS)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQS-1:0]            valid_in,
   input  logic [NUM_REQS*DATA_WIDTH-1:0] data_in,
   input  logic [NUM_REQS-1:0]            last_in,
   output logic [NUM_REQS-1:0]            ready_in,
   output logic                           valid_out,
   output logic [DATA_WIDTH-1:0]          data_out,
   output logic                           last_out,
   output logic [LOG_NUM_REQS-1:0]        sel_out,
   input  logic                           ready_out
);
   typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_e;

   localparam logic [LOG_NUM_REQS-1:0] LAST_IDX = LOG_NUM_REQS'(NUM_REQS - 1);

   state_e                  state_r;
   logic [LOG_NUM_REQS-1:0] rr_ptr_r;
   logic [LOG_NUM_REQS-1:0] owner_r;
   logic                    valid_out_r;
   logic [DATA_WIDTH-1:0]   data_out_r;
   logic                    last_out_r;
   logic [LOG_NUM_REQS-1:0] sel_out_r;

   logic [LOG_NUM_REQS-1:0] pick_idx_s;
   logic [NUM_REQS-1:0]     pick_onehot_s;
   logic                    pick_valid_s;
   logic                    out_free_s;
   logic                    grant_vld_s;
   logic [LOG_NUM_REQS-1:0] grant_idx_s;
   logic [NUM_REQS-1:0]     owner_onehot_s;
   logic [NUM_REQS-1:0]     grant_onehot_s;
   logic [DATA_WIDTH-1:0]   grant_data_s;
   logic                    grant_valid_in_s;
   logic                    grant_last_s;
   logic                    xfer_s;
   logic [LOG_NUM_REQS-1:0] next_ptr_s;

   vx_rr_pick #(
      .NUM_REQS     (NUM_REQS),
      .LOG_NUM_REQS (LOG_NUM_REQS)
   ) u_pick (
      .requests    (valid_in),
      .start_idx   (rr_ptr_r),
      .pick_idx    (pick_idx_s),
      .pick_onehot (pick_onehot_s),
      .pick_valid  (pick_valid_s)
   );

   // Payload mux of the granted requester and one-hot of the lock owner
   always_comb begin
      owner_onehot_s   = '0;
      grant_data_s     = '0;
      grant_valid_in_s = 1'b0;
      grant_last_s     = 1'b0;
      for (int i = 0; i < NUM_REQS; i++) begin
         owner_onehot_s[i] = (owner_r == LOG_NUM_REQS'(i));
         if (grant_idx_s == LOG_NUM_REQS'(i)) begin
            grant_data_s     = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            grant_valid_in_s = valid_in[i];
            grant_last_s     = last_in[i];
         end else begin
            grant_data_s     = grant_data_s;
         end
      end
   end

   // Grant source: the owner stays granted while locked, even with valid_in low
   always_comb begin
      out_free_s = !valid_out_r || ready_out;
      if (state_r == LOCKED) begin
         grant_idx_s    = owner_r;
         grant_onehot_s = owner_onehot_s;
         grant_vld_s    = 1'b1;
      end else begin
         grant_idx_s    = pick_idx_s;
         grant_onehot_s = pick_onehot_s;
         grant_vld_s    = pick_valid_s;
      end
   end

   // Accept handshake and next pointer; nothing is accepted during reset
   always_comb begin
      if (grant_vld_s && out_free_s && !reset) begin
         ready_in = grant_onehot_s;
      end else begin
         ready_in = '0;
      end
      xfer_s = grant_vld_s && out_free_s && !reset && grant_valid_in_s;
      // explicit compare keeps non-power-of-2 counts in range
      if (grant_idx_s == LAST_IDX) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = grant_idx_s + LOG_NUM_REQS'(1);
      end
   end

   // Packet lock FSM and round-robin pointer (moves only on a last beat)
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         rr_ptr_r <= '0;
         owner_r  <= '0;
      end else if (xfer_s) begin
         case (state_r)
            IDLE: begin
               if (grant_last_s) begin
                  rr_ptr_r <= next_ptr_s;
               end else begin
                  state_r <= LOCKED;
                  owner_r <= grant_idx_s;
               end
            end
            LOCKED: begin
               if (grant_last_s) begin
                  state_r  <= IDLE;
                  rr_ptr_r <= next_ptr_s;
               end else begin
                  state_r  <= LOCKED;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end else begin
         state_r <= state_r;
      end
   end

   // Output stage: load on transfer, drain on consumer accept, else hold
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_out_r <= 1'b0;
         data_out_r  <= '0;
         last_out_r  <= 1'b0;
         sel_out_r   <= '0;
      end else if (xfer_s) begin
         valid_out_r <= 1'b1;
         data_out_r  <= grant_data_s;
         last_out_r  <= grant_last_s;
         sel_out_r   <= grant_idx_s;
      end else if (ready_out) begin
         valid_out_r <= 1'b0;
      end else begin
         valid_out_r <= valid_out_r;
      end
   end

   assign valid_out = valid_out_r;
   assign data_out  = data_out_r;
   assign last_out  = last_out_r;
   assign sel_out   = sel_out_r;

   vx_packet_rr_scheduler_chk #(
      .NUM_REQS     (NUM_REQS),
      .LOG_NUM_REQS (LOG_NUM_REQS)
   ) u_chk (
      .clk      (clk),
      .reset    (reset),
      .ready_in (ready_in),
      .locked   (state_r == LOCKED),
      .owner    (owner_r)
   );

endmodule

// File: tb/tb_vx_packet_rr_scheduler.sv
// Bench for vx_packet_rr_scheduler: a 4-requester and a 3-requester instance
// are driven side by side and compared every cycle against a packet-level
// reference model, plus directed scenario checks.
module tb_vx_packet_rr_scheduler;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // per-unit stimulus: unit 0 is NUM_REQS=4, unit 1 is NUM_REQS=3
   logic [3:0]  iv [2];
   logic [3:0]  il [2];
   logic [31:0] id [2][4];
   logic        iro [2];

   logic [127:0] d4;
   logic [95:0]  d3;
   logic [2:0]   v3, l3;
   assign d4 = {id[0][3], id[0][2], id[0][1], id[0][0]};
   assign d3 = {id[1][2], id[1][1], id[1][0]};
   assign v3 = iv[1][2:0];
   assign l3 = il[1][2:0];

   logic [3:0]  ri4;
   logic        vo4, lo4;
   logic [31:0] dout4;
   logic [1:0]  so4;
   logic [2:0]  ri3;
   logic        vo3, lo3;
   logic [31:0] dout3;
   logic [1:0]  so3;

   vx_packet_rr_scheduler #(.NUM_REQS(4), .DATA_WIDTH(32)) dut4 (
      .clk(clk), .reset(reset), .valid_in(iv[0]), .data_in(d4), .last_in(il[0]),
      .ready_in(ri4), .valid_out(vo4), .data_out(dout4), .last_out(lo4),
      .sel_out(so4), .ready_out(iro[0]));

   vx_packet_rr_scheduler #(.NUM_REQS(3), .DATA_WIDTH(32)) dut3 (
      .clk(clk), .reset(reset), .valid_in(v3), .data_in(d3), .last_in(l3),
      .ready_in(ri3), .valid_out(vo3), .data_out(dout3), .last_out(lo3),
      .sel_out(so3), .ready_out(iro[1]));

   int vectors = 0;
   int miscompares = 0;

   // reference model: packet lock, pointer and the output beat
   bit          m_vout [2];
   logic [31:0] m_data [2];
   bit          m_last [2];
   int          m_sel [2];
   bit          m_locked [2];
   int          m_owner [2];
   int          m_ptr [2];
   logic [3:0]  acc [2];

   // random packet generators
   bit pend [2][4];
   int left [2][4];

   // One clock: check ready_in against the model, clock, check outputs
   task automatic tick();
      logic [3:0]  exp_rdy;
      logic [3:0]  got_rdy;
      bit          xf [2];
      int          gi [2];
      logic [31:0] cd [2];
      bit          cl [2];
      bit          rst;
      bit          gv, ofree;
      int          g;
      bit          got_v, got_l;
      logic [31:0] got_d;
      logic [1:0]  got_s;
      #1;
      rst = reset;
      for (int u = 0; u < 2; u++) begin
         int n;
         n = (u == 0) ? 4 : 3;
         got_rdy = (u == 0) ? ri4 : {1'b0, ri3};
         ofree = !m_vout[u] || iro[u];
         gv = 1'b0;
         g = 0;
         if (m_locked[u]) begin
            gv = 1'b1;
            g = m_owner[u];
         end else begin
            for (int k = 0; k < n; k++) begin
               if (!gv && iv[u][(m_ptr[u] + k) % n]) begin
                  gv = 1'b1;
                  g = (m_ptr[u] + k) % n;
               end
            end
         end
         exp_rdy = (gv && ofree && !rst) ? (4'b0001 << g) : 4'b0000;
         xf[u] = (exp_rdy != 4'b0000) && iv[u][g];
         gi[u] = g;
         cd[u] = id[u][g];
         cl[u] = il[u][g];
         acc[u] = xf[u] ? exp_rdy : 4'b0000;
         vectors++;
         if (got_rdy !== exp_rdy) begin
            miscompares++;
            $display("FAIL ready_in unit%0d @%0t: got %b expected %b", u, $time, got_rdy, exp_rdy);
         end
      end
      @(posedge clk);
      for (int u = 0; u < 2; u++) begin
         int n;
         n = (u == 0) ? 4 : 3;
         if (rst) begin
            m_vout[u] = 1'b0; m_data[u] = 32'd0; m_last[u] = 1'b0; m_sel[u] = 0;
            m_locked[u] = 1'b0; m_owner[u] = 0; m_ptr[u] = 0;
         end else if (xf[u]) begin
            m_vout[u] = 1'b1; m_data[u] = cd[u]; m_last[u] = cl[u]; m_sel[u] = gi[u];
            if (cl[u]) begin
               m_locked[u] = 1'b0;
               m_ptr[u] = (gi[u] + 1) % n;
            end else begin
               m_locked[u] = 1'b1;
               m_owner[u] = gi[u];
            end
         end else if (iro[u]) begin
            m_vout[u] = 1'b0;
         end
      end
      #1;
      for (int u = 0; u < 2; u++) begin
         got_v = (u == 0) ? vo4 : vo3;
         got_d = (u == 0) ? dout4 : dout3;
         got_l = (u == 0) ? lo4 : lo3;
         got_s = (u == 0) ? so4 : so3;
         vectors++;
         if (got_v !== m_vout[u] || got_d !== m_data[u] || got_l !== m_last[u] || got_s !== 2'(m_sel[u])) begin
            miscompares++;
            $display("FAIL outputs unit%0d @%0t: got v=%b d=%h l=%b s=%0d expected v=%b d=%h l=%b s=%0d",
                     u, $time, got_v, got_d, got_l, got_s, m_vout[u], m_data[u], m_last[u], m_sel[u]);
         end
      end
   endtask

   // New payload for every beat that was just accepted
   task automatic refresh();
      for (int u = 0; u < 2; u++)
         for (int i = 0; i < 4; i++)
            if (acc[u][i]) id[u][i] = $urandom;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int u = 0; u < 2; u++) begin
         iv[u] = 4'b0000; il[u] = 4'b0000; iro[u] = 1'b1;
         for (int i = 0; i < 4; i++) begin
            id[u][i] = $urandom; pend[u][i] = 1'b0; left[u][i] = 0;
         end
      end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (vo4 !== 1'b0 || dout4 !== 32'd0 || lo4 !== 1'b0 || so4 !== 2'd0 || vo3 !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: got v=%b d=%h l=%b s=%0d v3=%b expected all zero", vo4, dout4, lo4, so4, vo3);
      end
   endtask

   task automatic test_rr_single_beat();
      do_reset();
      iv[0] = 4'b1111; il[0] = 4'b1111; iro[0] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         refresh();
         vectors++;
         if (vo4 !== 1'b1 || so4 !== 2'(k % 4)) begin
            miscompares++;
            $display("FAIL rr_sequence beat %0d: got v=%b sel=%0d expected v=1 sel=%0d", k, vo4, so4, k % 4);
         end
      end
   endtask

   task automatic test_packet_lock();
      do_reset();
      iv[0] = 4'b0110; il[0] = 4'b0100; iro[0] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         il[0][1] = (c == 2);
         #1;
         if (c < 3) begin
            vectors++;
            if (ri4[2] !== 1'b0) begin
               miscompares++;
               $display("FAIL lock_blocks_req2 cycle %0d: got ready_in=%b expected bit2=0", c, ri4);
            end
         end
         tick();
         refresh();
         vectors++;
         if (so4 !== ((c < 3) ? 2'd1 : 2'd2)) begin
            miscompares++;
            $display("FAIL lock_sel cycle %0d: got %0d expected %0d", c, so4, (c < 3) ? 1 : 2);
         end
      end
   endtask

   task automatic test_owner_gap();
      do_reset();
      iv[0] = 4'b0010; il[0] = 4'b0000; iro[0] = 1'b1;
      tick();
      refresh();
      for (int c = 0; c < 2; c++) begin
         iv[0] = 4'b1101; il[0] = 4'b1101;
         #1;
         vectors++;
         if ((ri4 & 4'b1101) !== 4'b0000) begin
            miscompares++;
            $display("FAIL gap_blocks_others cycle %0d: got ready_in=%b expected others 0", c, ri4);
         end
         tick();
      end
      for (int c = 0; c < 3; c++) begin
         iv[0] = 4'b1111; il[0] = 4'b1101;
         il[0][1] = (c == 1);
         tick();
         refresh();
         vectors++;
         if (so4 !== ((c < 2) ? 2'd1 : 2'd2) || vo4 !== 1'b1) begin
            miscompares++;
            $display("FAIL gap_resume cycle %0d: got v=%b sel=%0d expected v=1 sel=%0d", c, vo4, so4, (c < 2) ? 1 : 2);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] saved;
      do_reset();
      iv[0] = 4'b1111; il[0] = 4'b1111; iro[0] = 1'b1;
      saved = id[0][0];
      tick();
      refresh();
      iro[0] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++;
         if (ri4 !== 4'b0000) begin
            miscompares++;
            $display("FAIL stall_ready cycle %0d: got %b expected 0000", c, ri4);
         end
         tick();
         vectors++;
         if (vo4 !== 1'b1 || dout4 !== saved || lo4 !== 1'b1 || so4 !== 2'd0) begin
            miscompares++;
            $display("FAIL stall_hold cycle %0d: got v=%b d=%h l=%b s=%0d expected v=1 d=%h l=1 s=0",
                     c, vo4, dout4, lo4, so4, saved);
         end
      end
      saved = id[0][1];
      iro[0] = 1'b1;
      tick();
      refresh();
      vectors++;
      if (vo4 !== 1'b1 || so4 !== 2'd1 || dout4 !== saved) begin
         miscompares++;
         $display("FAIL stall_release: got v=%b s=%0d d=%h expected v=1 s=1 d=%h", vo4, so4, dout4, saved);
      end
   endtask

   task automatic test_wrap_three();
      do_reset();
      iv[1] = 4'b0100; il[1] = 4'b0111; iro[1] = 1'b1;
      tick();
      refresh();
      vectors++;
      if (so3 !== 2'd2) begin
         miscompares++;
         $display("FAIL wrap_first: got sel=%0d expected 2", so3);
      end
      iv[1] = 4'b0101;
      #1;
      vectors++;
      if (ri3 !== 3'b001) begin
         miscompares++;
         $display("FAIL wrap_ready: got %b expected 001", ri3);
      end
      tick();
      vectors++;
      if (so3 !== 2'd0) begin
         miscompares++;
         $display("FAIL wrap_second: got sel=%0d expected 0", so3);
      end
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      iv[0] = 4'b1000; il[0] = 4'b0000; iro[0] = 1'b1;
      tick();
      iro[0] = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      vectors++;
      if (ri4 !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_ready: got %b expected 0000", ri4);
      end
      tick();
      vectors++;
      if (vo4 !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_drop: got valid_out=%b expected 0", vo4);
      end
      reset = 1'b0;
      iv[0] = 4'b1111; il[0] = 4'b1111; iro[0] = 1'b1;
      #1;
      vectors++;
      if (ri4 !== 4'b0001) begin
         miscompares++;
         $display("FAIL reset_first_grant: got %b expected 0001", ri4);
      end
      tick();
      vectors++;
      if (so4 !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_first_sel: got %0d expected 0", so4);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < ((u == 0) ? 4 : 3); i++) begin
               if (!pend[u][i] && $urandom_range(0, 1) == 1) begin
                  if (left[u][i] == 0) left[u][i] = $urandom_range(1, 4);
                  pend[u][i] = 1'b1;
                  id[u][i] = $urandom;
                  il[u][i] = (left[u][i] == 1);
               end
               iv[u][i] = pend[u][i];
            end
            iro[u] = ($urandom_range(0, 3) != 0);
         end
         iv[1][3] = 1'b0;
         tick();
         for (int u = 0; u < 2; u++)
            for (int i = 0; i < 4; i++)
               if (acc[u][i]) begin
                  pend[u][i] = 1'b0;
                  left[u][i] = left[u][i] - 1;
               end
      end
   endtask

   initial begin
      for (int u = 0; u < 2; u++) begin
         m_vout[u] = 1'b0; m_data[u] = 32'd0; m_last[u] = 1'b0; m_sel[u] = 0;
         m_locked[u] = 1'b0; m_owner[u] = 0; m_ptr[u] = 0; acc[u] = 4'b0000;
      end
      test_reset();
      test_rr_single_beat();
      test_packet_lock();
      test_owner_gap();
      test_backpressure();
      test_wrap_three();
      test_reset_mid_packet();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
